prog_loader_monitor: RTL and testbench
======================================

Name: prog_loader_monitor

Overview:
- Hardware successor to the bench-side program load / halt-detect / memory-dump flow for the SPARC datapath.
- Streams program words into the byte-addressed RAM, big-endian, MSB byte at the lowest address.
- Holds the CPU in reset, releases it, then watches the instruction register for a halt word or a cycle timeout.
- Streams a configurable RAM window out as a dump.
- Sits between the RAM port mux and the CPU reset, replacing the file-driven initial block.

Parameters:
- WORD_W, 32, program word width; must be a multiple of 8 (BYTES = WORD_W/8).
- ADDR_W, 9, RAM byte-address width.
- NUM_WORDS, 128, load capacity in words.
- HALT_WORD, 32'h10800000, instruction value that marks end of program (branch-always).
- TIMEOUT, 10000, maximum RUN cycles before a forced stop.
- CPU_RST_CYC, 2, number of cycles cpu_reset is held after load.
- DUMP_BYTES, 52, number of bytes dumped, starting at address 0.

Ports:
- Clk  in  1  clock, rising edge.
- RESET_n  in  1  asynchronous, active-low reset.
- start  in  1  begin a session; sampled only in IDLE or DONE.
- load_valid  in  1  load_data is valid.
- load_data  in  WORD_W  program word.
- load_last  in  1  qualifies the final word of the program.
- load_ready  out  1  block can accept a word this cycle.
- mem_sel  out  1  1 = CPU owns the RAM port; 0 = this block owns it.
- mem_addr  out  ADDR_W  RAM byte address.
- mem_wdata  out  8  RAM write byte.
- mem_we  out  1  RAM write strobe.
- mem_rdata  in  8  RAM read byte, valid one cycle after mem_addr.
- cpu_reset  out  1  active-high reset to the CPU control unit.
- ir_value  in  WORD_W  CPU instruction register.
- ir_valid  in  1  ir_value was loaded this cycle.
- dump_valid  out  1  dump_addr and dump_data are valid.
- dump_addr  out  ADDR_W  address of the dumped byte.
- dump_data  out  8  dumped byte.
- busy  out  1  state is not IDLE or DONE.
- done  out  1  session complete; sticky until the next start.
- halted  out  1  session ended on HALT_WORD.
- timeout  out  1  session ended on TIMEOUT.
- overflow  out  1  a word was offered beyond NUM_WORDS.
- cycle_count  out  32  RUN cycles counted, including the terminating cycle.

Behaviour:
- Reset (async, RESET_n=0):
  - State IDLE.
  - cpu_reset=1; every other output 0; all counters cleared.
- Reset mid-operation aborts immediately. Writes already issued stay in RAM.
- States: IDLE, LOAD, WRITE, CPU_RST, RUN, DUMP, DONE.
- IDLE/DONE, start=1: clear halted, timeout, overflow, cycle_count and done, and the word pointer. Go to LOAD.
- LOAD:
  - load_ready=1.
  - On load_valid: latch the word and load_last, then go to WRITE.
  - If the word pointer already equals NUM_WORDS: the word is dropped, overflow=1, and no WRITE occurs. If load_last was set, go to CPU_RST; otherwise stay in LOAD.
- WRITE:
  - BYTES cycles, k=0..BYTES-1.
  - mem_we=1, mem_addr=ptr*BYTES+k, mem_wdata=word byte k, MSB first.
  - load_ready=0 throughout.
  - Then ptr+1. Go to CPU_RST if load_last was set, else LOAD.
- CPU_RST:
  - cpu_reset=1 for exactly CPU_RST_CYC cycles, mem_sel=0.
  - Then go to RUN.
- RUN:
  - cpu_reset=0, mem_sel=1; cycle_count increments every cycle.
  - ir_valid && ir_value==HALT_WORD: halted=1, go to DUMP.
  - Else if cycle_count reaches TIMEOUT: timeout=1, go to DUMP.
  - Halt wins when both occur in the same cycle.
  - cycle_count freezes on exit.
- DUMP:
  - cpu_reset=1, mem_sel=0, mem_we=0.
  - Addresses 0..DUMP_BYTES-1 are issued one per cycle.
  - dump_valid is asserted one cycle after each address, with the matching dump_addr/dump_data.
  - After the last byte, go to DONE.
  - Total DUMP_BYTES+1 cycles.
- DONE: done=1, cpu_reset=1, flags held.
- start is ignored in all states other than IDLE and DONE.
- Address arithmetic wraps modulo 2^ADDR_W. Integration must size NUM_WORDS*BYTES and DUMP_BYTES to fit the RAM.

Test Plan:
- Load 0xDEADBEEF then 0x10800000 with load_last → RAM bytes 0..7 = DE AD BE EF 10 80 00 00. mem_we high for 8 cycles total; load_ready low during each 4-cycle WRITE.
- After the last WRITE cycle → cpu_reset high exactly 2 cycles, then 0 with mem_sel=1 on the first RUN cycle; busy=1 throughout.
- In RUN, drive ir_valid with 0x10800000 on the 37th RUN cycle → halted=1, cycle_count=37. Dump emits addresses 0..51 with the correct bytes, one per cycle, then done=1.
- TIMEOUT=100, never present the halt word → timeout=1, halted=0, cycle_count=100, dump follows. A halt and the timeout in the same cycle → halted=1, timeout=0.
- NUM_WORDS=2, offer 3 words (third with load_last) → only bytes 0..7 written, overflow=1, flow proceeds to CPU_RST.
- Assert RESET_n=0 mid-DUMP → outputs immediately 0 and cpu_reset=1. After release, start begins a new session with flags cleared.

Source files
------------

// File: rtl/prog_loader_monitor_if.sv
// Signal bundle between prog_loader_monitor and its surroundings: program load stream,
// RAM byte port, CPU hooks, dump stream and session status.
interface prog_loader_monitor_if #(
  parameter int WORD_W = 32,
  parameter int ADDR_W = 9
);
  logic              start;
  logic              load_valid;
  logic [WORD_W-1:0] load_data;
  logic              load_last;
  logic              load_ready;
  logic              mem_sel;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_wdata;
  logic              mem_we;
  logic [7:0]        mem_rdata;
  logic              cpu_reset;
  logic [WORD_W-1:0] ir_value;
  logic              ir_valid;
  logic              dump_valid;
  logic [ADDR_W-1:0] dump_addr;
  logic [7:0]        dump_data;
  logic              busy;
  logic              done;
  logic              halted;
  logic              timeout;
  logic              overflow;
  logic [31:0]       cycle_count;

  modport master (
    input  start, load_valid, load_data, load_last, mem_rdata, ir_value, ir_valid,
    output load_ready, mem_sel, mem_addr, mem_wdata, mem_we, cpu_reset,
           dump_valid, dump_addr, dump_data, busy, done, halted, timeout, overflow, cycle_count
  );

  modport slave (
    output start, load_valid, load_data, load_last, mem_rdata, ir_value, ir_valid,
    input  load_ready, mem_sel, mem_addr, mem_wdata, mem_we, cpu_reset,
           dump_valid, dump_addr, dump_data, busy, done, halted, timeout, overflow, cycle_count
  );
endinterface

// File: rtl/prog_loader_monitor.sv
// Program loader / halt monitor: writes program words big-endian into RAM, runs the CPU
// until a halt word or timeout, then streams a fixed RAM window out as a dump.
module prog_loader_monitor #(
  parameter int                WORD_W      = 32,
  parameter int                ADDR_W      = 9,
  parameter int                NUM_WORDS   = 128,
  parameter logic [WORD_W-1:0] HALT_WORD   = WORD_W'(32'h1080_0000),
  parameter int                TIMEOUT     = 10000,
  parameter int                CPU_RST_CYC = 2,
  parameter int                DUMP_BYTES  = 52
) (
  input logic                   Clk,
  input logic                   RESET_n,
  prog_loader_monitor_if.master bus
);
  localparam int BYTES = WORD_W / 8;
  localparam int PTR_W = $clog2(NUM_WORDS + 1);
  localparam int BC_W  = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam int RC_W  = (CPU_RST_CYC > 1) ? $clog2(CPU_RST_CYC) : 1;
  localparam int DC_W  = $clog2(DUMP_BYTES + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_WRITE, S_CPU_RST, S_RUN, S_DUMP, S_DONE
  } state_t;

  state_t            state_q;
  logic [PTR_W-1:0]  ptr_q;
  logic [BC_W-1:0]   byte_cnt_q;
  logic [RC_W-1:0]   rst_cnt_q;
  logic [DC_W-1:0]   dump_cnt_q;
  logic [WORD_W-1:0] word_q;
  logic              last_q;
  logic              load_ready_q;
  logic              mem_sel_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [7:0]        mem_wdata_q;
  logic              mem_we_q;
  logic              cpu_reset_q;
  logic              dump_valid_q;
  logic [ADDR_W-1:0] dump_addr_q;
  logic              busy_q;
  logic              done_q;
  logic              halted_q;
  logic              timeout_q;
  logic              overflow_q;
  logic [31:0]       cycle_count_q;
  logic [31:0]       cycle_count_d;

  assign cycle_count_d = cycle_count_q + 32'd1;

  // Session sequencer; every output is a register updated together with the state.
  always_ff @(posedge Clk or negedge RESET_n) begin
    if (!RESET_n) begin
      state_q       <= S_IDLE;
      ptr_q         <= '0;
      byte_cnt_q    <= '0;
      rst_cnt_q     <= '0;
      dump_cnt_q    <= '0;
      word_q        <= '0;
      last_q        <= 1'b0;
      load_ready_q  <= 1'b0;
      mem_sel_q     <= 1'b0;
      mem_addr_q    <= '0;
      mem_wdata_q   <= 8'h00;
      mem_we_q      <= 1'b0;
      cpu_reset_q   <= 1'b1;
      dump_valid_q  <= 1'b0;
      dump_addr_q   <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      halted_q      <= 1'b0;
      timeout_q     <= 1'b0;
      overflow_q    <= 1'b0;
      cycle_count_q <= 32'd0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (bus.start) begin
            state_q       <= S_LOAD;
            load_ready_q  <= 1'b1;
            busy_q        <= 1'b1;
            done_q        <= 1'b0;
            halted_q      <= 1'b0;
            timeout_q     <= 1'b0;
            overflow_q    <= 1'b0;
            cycle_count_q <= 32'd0;
            ptr_q         <= '0;
          end
        end
        S_LOAD: begin
          if (bus.load_valid) begin
            last_q <= bus.load_last;
            if (ptr_q == PTR_W'(NUM_WORDS)) begin
              // Capacity exhausted: drop the word but still honour load_last.
              overflow_q <= 1'b1;
              if (bus.load_last) begin
                state_q      <= S_CPU_RST;
                load_ready_q <= 1'b0;
                rst_cnt_q    <= '0;
              end
            end else begin
              state_q      <= S_WRITE;
              load_ready_q <= 1'b0;
              mem_we_q     <= 1'b1;
              mem_addr_q   <= ADDR_W'(int'(ptr_q) * BYTES);
              mem_wdata_q  <= bus.load_data[WORD_W-1 -: 8];
              word_q       <= bus.load_data << 8;
              byte_cnt_q   <= '0;
            end
          end
        end
        S_WRITE: begin
          if (byte_cnt_q == BC_W'(BYTES - 1)) begin
            mem_we_q    <= 1'b0;
            mem_wdata_q <= 8'h00;
            ptr_q       <= ptr_q + PTR_W'(1);
            if (last_q) begin
              state_q   <= S_CPU_RST;
              rst_cnt_q <= '0;
            end else begin
              state_q      <= S_LOAD;
              load_ready_q <= 1'b1;
            end
          end else begin
            byte_cnt_q  <= byte_cnt_q + BC_W'(1);
            mem_addr_q  <= mem_addr_q + ADDR_W'(1);
            mem_wdata_q <= word_q[WORD_W-1 -: 8];
            word_q      <= word_q << 8;
          end
        end
        S_CPU_RST: begin
          if (rst_cnt_q == RC_W'(CPU_RST_CYC - 1)) begin
            state_q     <= S_RUN;
            cpu_reset_q <= 1'b0;
            mem_sel_q   <= 1'b1;
          end else begin
            rst_cnt_q <= rst_cnt_q + RC_W'(1);
          end
        end
        S_RUN: begin
          cycle_count_q <= cycle_count_d;
          // Halt is tested first so it wins over a coincident timeout.
          if ((bus.ir_valid && (bus.ir_value == HALT_WORD)) || (cycle_count_d == 32'(TIMEOUT))) begin
            if (bus.ir_valid && (bus.ir_value == HALT_WORD)) begin
              halted_q <= 1'b1;
            end else begin
              timeout_q <= 1'b1;
            end
            state_q     <= S_DUMP;
            cpu_reset_q <= 1'b1;
            mem_sel_q   <= 1'b0;
            mem_addr_q  <= '0;
            dump_cnt_q  <= '0;
          end
        end
        S_DUMP: begin
          if (dump_cnt_q == DC_W'(DUMP_BYTES)) begin
            state_q      <= S_DONE;
            dump_valid_q <= 1'b0;
            done_q       <= 1'b1;
            busy_q       <= 1'b0;
          end else begin
            dump_valid_q <= 1'b1;
            dump_addr_q  <= mem_addr_q;
            dump_cnt_q   <= dump_cnt_q + DC_W'(1);
            if (dump_cnt_q != DC_W'(DUMP_BYTES - 1)) begin
              mem_addr_q <= mem_addr_q + ADDR_W'(1);
            end
          end
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.load_ready  = load_ready_q;
  assign bus.mem_sel     = mem_sel_q;
  assign bus.mem_addr    = mem_addr_q;
  assign bus.mem_wdata   = mem_wdata_q;
  assign bus.mem_we      = mem_we_q;
  assign bus.cpu_reset   = cpu_reset_q;
  assign bus.dump_valid  = dump_valid_q;
  assign bus.dump_addr   = dump_addr_q;
  // RAM read data arrives one cycle after the address, i.e. alongside dump_valid.
  assign bus.dump_data   = dump_valid_q ? bus.mem_rdata : 8'h00;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.halted      = halted_q;
  assign bus.timeout     = timeout_q;
  assign bus.overflow    = overflow_q;
  assign bus.cycle_count = cycle_count_q;
endmodule

// File: tb/tb_prog_loader_monitor.sv
// Randomized scoreboard bench for prog_loader_monitor with a byte-array RAM reference model.
module tb_prog_loader_monitor;
  localparam int          WORD_W      = 32;
  localparam int          ADDR_W      = 9;
  localparam int          NUM_WORDS   = 4;
  localparam int          TIMEOUT     = 100;
  localparam int          CPU_RST_CYC = 2;
  localparam int          DUMP_BYTES  = 52;
  localparam logic [31:0] HALT        = 32'h1080_0000;

  typedef struct packed {
    logic [8:0] a;
    logic [7:0] d;
  } bt_t;

  typedef struct packed {
    logic        halted;
    logic        timeout;
    logic        overflow;
    logic [31:0] count;
  } sess_t;

  logic Clk = 1'b0;
  logic RESET_n = 1'b0;

  prog_loader_monitor_if #(.WORD_W(WORD_W), .ADDR_W(ADDR_W)) bus ();

  prog_loader_monitor #(
    .WORD_W(WORD_W), .ADDR_W(ADDR_W), .NUM_WORDS(NUM_WORDS), .HALT_WORD(HALT),
    .TIMEOUT(TIMEOUT), .CPU_RST_CYC(CPU_RST_CYC), .DUMP_BYTES(DUMP_BYTES)
  ) dut (
    .Clk(Clk),
    .RESET_n(RESET_n),
    .bus(bus)
  );

  always #5 Clk = ~Clk;

  logic [7:0]  ram [512];
  logic [7:0]  exp_ram [512];
  logic [7:0]  rdata_r;
  logic [31:0] wbuf [8];

  bt_t   wr_q[$];
  bt_t   dump_q[$];
  sess_t sess_q[$];

  int   errors = 0;
  int   checks = 0;
  int   wcount = 0;
  logic done_prev = 1'b0;

  // Synchronous-read RAM seen by the DUT.
  always @(posedge Clk) begin
    if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_wdata;
    rdata_r <= ram[bus.mem_addr];
  end
  assign bus.mem_rdata = rdata_r;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: pops expectations whenever the DUT presents a write, a dump byte or session end.
  always @(negedge Clk) begin
    bt_t   e;
    sess_t s;
    if (bus.mem_we) begin
      wcount++;
      chk("ready_low_in_write", bus.load_ready, 0);
      if (wr_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_write: addr %0h data %0h with nothing expected", bus.mem_addr, bus.mem_wdata);
      end else begin
        e = wr_q.pop_front();
        chk("write_addr", bus.mem_addr, e.a);
        chk("write_data", bus.mem_wdata, e.d);
      end
    end
    if (bus.dump_valid) begin
      if (dump_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_dump: addr %0h data %0h with nothing expected", bus.dump_addr, bus.dump_data);
      end else begin
        e = dump_q.pop_front();
        chk("dump_addr", bus.dump_addr, e.a);
        chk("dump_data", bus.dump_data, e.d);
      end
    end
    if (bus.done && !done_prev) begin
      if (sess_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_done: session ended with nothing expected");
      end else begin
        s = sess_q.pop_front();
        chk("halted", bus.halted, s.halted);
        chk("timeout", bus.timeout, s.timeout);
        chk("overflow", bus.overflow, s.overflow);
        chk("cycle_count", bus.cycle_count, s.count);
      end
    end
    done_prev = bus.done;
  end

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_cpu_reset"}, bus.cpu_reset, 1);
    chk({tag, "_load_ready"}, bus.load_ready, 0);
    chk({tag, "_mem_sel"}, bus.mem_sel, 0);
    chk({tag, "_mem_we"}, bus.mem_we, 0);
    chk({tag, "_mem_addr"}, bus.mem_addr, 0);
    chk({tag, "_dump_valid"}, bus.dump_valid, 0);
    chk({tag, "_dump_data"}, bus.dump_data, 0);
    chk({tag, "_busy"}, bus.busy, 0);
    chk({tag, "_done"}, bus.done, 0);
    chk({tag, "_flags"}, {bus.halted, bus.timeout, bus.overflow}, 0);
    chk({tag, "_cycle_count"}, bus.cycle_count, 0);
  endtask

  task automatic send_word(input logic [31:0] w, input logic last);
    bit ok;
    ok = 1'b0;
    bus.load_valid = 1'b1;
    bus.load_data  = w;
    bus.load_last  = last;
    for (int k = 0; k < 50 && !ok; k++) begin
      if (bus.load_ready) begin
        @(posedge Clk);
        ok = 1'b1;
      end else begin
        @(negedge Clk);
      end
    end
    chk("load_accept", ok, 1);
  endtask

  task automatic fill_rand();
    for (int i = 0; i < 8; i++) wbuf[i] = $urandom;
  endtask

  task automatic run_session(input int nw, input int halt_cyc, input bit poke, input bit abort);
    int          exp_wr, w0, rc, end_cyc, busy_bad, gap, wait_n;
    bit          ovf, seen;
    sess_t       s;
    bt_t         e;
    logic [31:0] v;
    exp_wr = 0; rc = 0; busy_bad = 0; ovf = 1'b0; seen = 1'b0;
    @(negedge Clk); bus.start = 1'b1;
    @(negedge Clk); bus.start = 1'b0;
    chk("start_done_clear", bus.done, 0);
    chk("start_flags_clear", {bus.halted, bus.timeout, bus.overflow}, 0);
    chk("start_count_clear", bus.cycle_count, 0);
    chk("start_busy", bus.busy, 1);
    chk("start_ready", bus.load_ready, 1);
    w0 = wcount;
    for (int i = 0; i < nw; i++) begin
      gap = $urandom_range(0, 2);
      for (int g = 0; g < gap; g++) @(negedge Clk);
      if (i < NUM_WORDS) begin
        for (int b = 0; b < 4; b++) begin
          e.a = 9'(i * 4 + b);
          e.d = wbuf[i][31 - 8 * b -: 8];
          wr_q.push_back(e);
          exp_ram[i * 4 + b] = e.d;
        end
        exp_wr += 4;
      end else begin
        ovf = 1'b1;
      end
      send_word(wbuf[i], i == nw - 1);
      @(negedge Clk);
      bus.load_valid = 1'b0;
    end
    for (int k = 0; k < 60 && !seen; k++) begin
      if (bus.mem_sel) begin
        seen = 1'b1;
      end else begin
        if (bus.cpu_reset && !bus.mem_we) rc++;
        if (!bus.busy) busy_bad++;
        @(negedge Clk);
      end
    end
    chk("run_entered", seen, 1);
    chk("cpu_rst_cycles", rc, CPU_RST_CYC);
    chk("run_cpu_reset_low", bus.cpu_reset, 0);
    chk("busy_through_load", busy_bad, 0);
    chk("write_count", wcount - w0, exp_wr);
    if (halt_cyc >= 1 && halt_cyc <= TIMEOUT) begin
      end_cyc = halt_cyc; s.halted = 1'b1; s.timeout = 1'b0;
    end else begin
      end_cyc = TIMEOUT; s.halted = 1'b0; s.timeout = 1'b1;
    end
    s.overflow = ovf;
    s.count    = 32'(end_cyc);
    sess_q.push_back(s);
    for (int j = 0; j < DUMP_BYTES; j++) begin
      e.a = 9'(j);
      e.d = exp_ram[j];
      dump_q.push_back(e);
    end
    for (int n = 1; n <= end_cyc; n++) begin
      if (n == halt_cyc) begin
        bus.ir_valid = 1'b1;
        bus.ir_value = HALT;
      end else begin
        v = $urandom;
        if (v == HALT) v = v ^ 32'h1;
        bus.ir_valid = 1'($urandom_range(0, 1));
        if ($urandom_range(0, 7) == 0) begin
          bus.ir_valid = 1'b0;
          v = HALT;
        end
        bus.ir_value = v;
      end
      bus.start = poke ? 1'($urandom_range(0, 1)) : 1'b0;
      @(negedge Clk);
    end
    bus.ir_valid = 1'b0;
    bus.start    = 1'b0;
    if (abort) begin
      wait_n = $urandom_range(3, 40);
      for (int k = 0; k < wait_n; k++) @(negedge Clk);
      #2 RESET_n = 1'b0;
      #1 check_reset_outputs("abort");
      dump_q.delete();
      sess_q.delete();
      wr_q.delete();
      @(negedge Clk);
      RESET_n = 1'b1;
    end else begin
      for (int k = 0; k < 200 && !bus.done; k++) @(negedge Clk);
      chk("done_seen", bus.done, 1);
      @(negedge Clk);
      chk("dump_all_seen", dump_q.size(), 0);
      chk("session_popped", sess_q.size(), 0);
      chk("done_sticky", bus.done, 1);
      chk("done_busy_low", bus.busy, 0);
      chk("done_cpu_reset", bus.cpu_reset, 1);
    end
  endtask

  initial begin
    logic [7:0] b;
    int         h;
    bus.start      = 1'b0;
    bus.load_valid = 1'b0;
    bus.load_data  = 32'h0;
    bus.load_last  = 1'b0;
    bus.ir_value   = 32'h0;
    bus.ir_valid   = 1'b0;
    for (int i = 0; i < 512; i++) begin
      b = 8'($urandom);
      ram[i] <= b;
      exp_ram[i] = b;
    end
    #12;
    check_reset_outputs("reset");
    @(negedge Clk);
    RESET_n = 1'b1;

    wbuf[0] = 32'hDEAD_BEEF;
    wbuf[1] = HALT;
    run_session(2, 37, 1'b0, 1'b0);
    fill_rand(); run_session(3, 0, 1'b1, 1'b0);
    fill_rand(); run_session(1, 100, 1'b0, 1'b0);
    fill_rand(); run_session(6, 10, 1'b0, 1'b0);
    fill_rand(); run_session(2, 5, 1'b0, 1'b1);
    fill_rand(); run_session(1, 1, 1'b0, 1'b0);
    for (int r = 0; r < 7; r++) begin
      fill_rand();
      h = $urandom_range(0, 105);
      run_session($urandom_range(1, 6), h, 1'($urandom_range(0, 1)), 1'b0);
    end
    @(negedge Clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1);
  end
endmodule
